lm_sm_sequencer: RTL
====================

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

Interface
REQ-001 Parameter NUM_REGS, default 8; number of architectural registers and the width of the transfer mask.
REQ-002 Parameter ADDR_W, default 16; memory address width.
REQ-003 Parameter DATA_W, default 16; register and memory data width.
REQ-004 Derived constant IDX_W = clog2(NUM_REGS); register index width.
REQ-005 Port clk, input, 1; single clock, all state changes on the rising edge.
REQ-006 Port proc_rst, input, 1; reset, asynchronous and active-high.
REQ-007 Port start, input, 1; request a multi-register transfer.
REQ-008 Port is_store, input, 1; 1 = store-multiple (RF to memory), 0 = load-multiple (memory to RF).
REQ-009 Port reg_mask, input, NUM_REGS; bit i set = transfer register i.
REQ-010 Port base_addr, input, ADDR_W; memory address of the first transfer.
REQ-011 Port busy, output, 1; high in every state except IDLE.
REQ-012 Port done, output, 1; one-cycle completion pulse.
REQ-013 Port xfer_count, output, IDX_W+1; number of transfers completed in the current or last operation.
REQ-014 Ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, DATA_W), mem_ack (in, 1), mem_rdata (in, DATA_W); variable-latency memory request/acknowledge interface.
REQ-015 Ports rf_raddr (out, IDX_W), rf_rdata (in, DATA_W; combinational read); rf_we (out, 1), rf_waddr (out, IDX_W), rf_wdata (out, DATA_W); register-file access.

Function
REQ-016 FSM states: IDLE, SCAN, MEM, WB, DONE.
REQ-017 IDLE: when start=1, latch reg_mask into pend_mask, base_addr into addr_reg and is_store into op_st; clear xfer_count; go to SCAN. While busy=1, start is ignored.
REQ-018 SCAN: cur_idx = lowest set bit of pend_mask. If pend_mask is zero, go to DONE. Otherwise go to MEM and register cur_idx.
REQ-019 SCAN with a store: rf_raddr = cur_idx combinationally; rf_rdata is captured into mem_wdata on SCAN exit.
REQ-020 MEM: mem_req=1; mem_we=op_st; mem_addr=addr_reg; mem_wdata stable. Hold all of these until a cycle with mem_ack=1. mem_ack outside MEM is ignored.
REQ-021 MEM, on the ack cycle:
  - clear pend_mask[cur_idx];
  - addr_reg += 1, wrapping modulo 2^ADDR_W;
  - xfer_count += 1.
REQ-022 MEM ack exit for a load: capture mem_rdata and go to WB. Exit for a store: go to SCAN. mem_req drops in the cycle after ack.
REQ-023 WB: one cycle with rf_we=1, rf_waddr=cur_idx and rf_wdata=captured data; then go to SCAN.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE. xfer_count holds until the next accepted start.
REQ-025 Transfers occur in ascending register index order; memory addresses are consecutive from base_addr.
REQ-026 Latency with zero-wait memory (ack in the first MEM cycle), start sampled at edge 0:
  - store: 2 cycles per register;
  - load: 3 cycles per register;
  - plus SCAN+DONE: done is high in cycle 2 + per-register cost.
REQ-027 Empty mask: no memory or RF access; done is high in the second cycle after start.
REQ-028 All-ones mask with NUM_REGS=8: xfer_count reaches 8 (IDX_W+1 bits, no overflow).
REQ-029 rf_we, mem_req and done are never asserted in the same cycle.

Reset
REQ-030 On proc_rst=1 (asynchronous):
  - state = IDLE;
  - busy, done, mem_req, mem_we, rf_we = 0;
  - pend_mask, addr_reg, xfer_count, mem_addr, mem_wdata, rf_waddr, rf_wdata, rf_raddr, cur_idx = 0.
REQ-031 Reset during MEM or WB aborts the operation. mem_req and rf_we fall immediately, without waiting for clk. A pending ack is discarded.
REQ-032 After reset deassertion, the first accepted start behaves identically to one following power-up.

Structure
REQ-033 Package lm_sm_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-034 Lowest-set-bit selection SHALL be a sub-module lsb_prio_enc (parameter NUM_REGS; outputs index and valid).

Verification
REQ-035 Store, mask=8'b0000_0101, base=16'h0040, zero-wait memory -> writes R0 data @0040, R2 data @0041; done in cycle 6; xfer_count=2.
REQ-036 Load, mask=8'b1000_0001, base=16'hFFFF, ack after 3 wait cycles -> R0 <- mem[FFFF], R7 <- mem[0000] (address wraps); xfer_count=2; mem_req held through the waits.
REQ-037 Mask=0, either op -> done in cycle 2; no mem_req and no rf_we asserted.
REQ-038 Load, mask=8'hFF, zero-wait -> 8 rf_we pulses with indices 0..7 in order; done in cycle 26; xfer_count=8.
REQ-039 proc_rst pulsed mid-MEM of the second transfer of a 4-register store -> mem_req falls asynchronously; busy=0 and xfer_count=0; a subsequent start with mask 8'h03 completes normally.
REQ-040 start held high through an entire operation and the done cycle -> a second operation begins only from IDLE, with one idle cycle after done.

Source files
------------

// File: rtl/lm_sm_pkg.sv
// Shared definitions for the load/store-multiple sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lm_sm_pkg;

    // Default geometry: eight 16-bit registers, 16-bit word address space.
    localparam int LM_NUM_REGS = 8;
    localparam int LM_ADDR_W   = 16;
    localparam int LM_DATA_W   = 16;

    // Sequencer control states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_MEM  = 3'd2,
        ST_WB   = 3'd3,
        ST_DONE = 3'd4
    } lm_state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder over the pending register mask.
// Latency: combinational.
// Backpressure: none; o_vld low means the mask is empty and o_idx is 0.
module lsb_prio_enc
    import lm_sm_pkg::*;
#(
    parameter  int NUM_REGS = LM_NUM_REGS,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0] i_mask,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_vld
);

    // Scan from the top down so the lowest set bit is the last assignment to win.
    always_comb begin
        o_idx = '0;
        o_vld = |i_mask;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask lowest-first, one memory beat per register.
// Latency: store 2 cycles/reg, load 3 cycles/reg, plus one SCAN and one DONE cycle; each memory wait adds a cycle.
// Backpressure: mem_req/addr/data are held until mem_ack; start is ignored while busy.
module lm_sm_sequencer
    import lm_sm_pkg::*;
#(
    parameter  int NUM_REGS = LM_NUM_REGS,
    parameter  int ADDR_W   = LM_ADDR_W,
    parameter  int DATA_W   = LM_DATA_W,
    localparam int IDX_W    = $clog2(NUM_REGS),
    localparam int CNT_W    = IDX_W + 1
) (
    input  logic                clk,
    input  logic                proc_rst,
    input  logic                start,
    input  logic                is_store,
    input  logic [NUM_REGS-1:0] reg_mask,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    xfer_count,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [IDX_W-1:0]    rf_raddr,
    input  logic [DATA_W-1:0]   rf_rdata,
    output logic                rf_we,
    output logic [IDX_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata
);

    lm_state_t             r_state;
    logic [NUM_REGS-1:0]   r_pend_mask;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_op_st;
    logic [IDX_W-1:0]      r_cur_idx;
    logic [CNT_W-1:0]      r_xfer_count;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic                  r_rf_we;
    logic [IDX_W-1:0]      r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;

    logic [IDX_W-1:0]      w_lsb_idx;
    logic                  w_lsb_vld;

    lsb_prio_enc #(
        .NUM_REGS (NUM_REGS)
    ) u_lsb_prio_enc (
        .i_mask (r_pend_mask),
        .o_idx  (w_lsb_idx),
        .o_vld  (w_lsb_vld)
    );

    // Sequencer FSM with registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            r_state      <= ST_IDLE;
            r_pend_mask  <= '0;
            r_addr       <= '0;
            r_op_st      <= 1'b0;
            r_cur_idx    <= '0;
            r_xfer_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_pend_mask  <= reg_mask;
                        r_addr       <= base_addr;
                        r_op_st      <= is_store;
                        r_xfer_count <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_lsb_vld) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cur_idx <= w_lsb_idx;
                        // Store data is sampled from the RF port as the request is launched.
                        if (r_op_st) begin
                            r_mem_wdata <= rf_rdata;
                        end
                        r_mem_req <= 1'b1;
                        r_mem_we  <= r_op_st;
                        r_state   <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        r_pend_mask[r_cur_idx] <= 1'b0;
                        r_addr                 <= r_addr + ADDR_W'(1);
                        r_xfer_count           <= r_xfer_count + CNT_W'(1);
                        r_mem_req              <= 1'b0;
                        r_mem_we               <= 1'b0;
                        if (r_op_st) begin
                            r_state <= ST_SCAN;
                        end else begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_cur_idx;
                            r_rf_wdata <= mem_rdata;
                            r_state    <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    r_rf_we <= 1'b0;
                    r_state <= ST_SCAN;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_rf_we   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign xfer_count = r_xfer_count;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_mem_wdata;
    assign rf_raddr   = w_lsb_idx;
    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;

endmodule
